// File: rtl/sdiv_r32m_pkg.sv
// rtl/sdiv_r32m_pkg.sv - shared divide op codes, FSM state type and helpers
package sdiv_r32m_pkg;

  // Operation codes, equal to funct3[1:0] of the RV32M divide group
  localparam logic [1:0] DIVC  = 2'b00;
  localparam logic [1:0] DIVUC = 2'b01;
  localparam logic [1:0] REMC  = 2'b10;
  localparam logic [1:0] REMUC = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    ADJUST = 2'b10,
    DONE   = 2'b11
  } state_t;

  // Signed ops are the ones with code bit 0 clear (DIVC, REMC)
  function automatic logic isSignedDiv(input logic [1:0] code);
    return ~code[0];
  endfunction

endpackage

// File: rtl/div_core_r32m.sv
// rtl/div_core_r32m.sv - radix-2 restoring shift/subtract datapath with iteration counter
module div_core_r32m
  import sdiv_r32m_pkg::*;
#(
  parameter int dataW = 32
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             load,
  input  logic             step,
  input  logic [dataW-1:0] dividendMag,
  input  logic [dataW-1:0] divisorMag,
  output logic [dataW-1:0] quo,
  output logic [dataW-1:0] rem,
  output logic             last
);

  localparam int cntW = $clog2(dataW);

  logic [dataW-1:0] quo_q;
  logic [dataW-1:0] rem_q;
  logic [dataW-1:0] dmag_q;
  logic [cntW-1:0]  cnt_q;

  // Partial remainder shifted left with the next dividend bit; one extra bit
  // so the trial subtraction borrow shows up in the MSB.
  logic [dataW:0] shifted;
  logic [dataW:0] diff;

  assign shifted = {rem_q, quo_q[dataW-1]};
  assign diff    = shifted - {1'b0, dmag_q};

  // Operand load, then one quotient bit per step with restore on borrow
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dmag_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      quo_q  <= dividendMag;
      rem_q  <= '0;
      dmag_q <= divisorMag;
      cnt_q  <= cntW'(dataW - 1);
    end else if (step) begin
      if (!diff[dataW]) begin
        rem_q <= diff[dataW-1:0];
        quo_q <= {quo_q[dataW-2:0], 1'b1};
      end else begin
        rem_q <= shifted[dataW-1:0];
        quo_q <= {quo_q[dataW-2:0], 1'b0};
      end
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign quo  = quo_q;
  assign rem  = rem_q;
  assign last = (cnt_q == '0);

endmodule

// File: rtl/sdiv_r32m.sv
// rtl/sdiv_r32m.sv - iterative RV32M DIV/DIVU/REM/REMU unit with start/done handshake
module sdiv_r32m
  import sdiv_r32m_pkg::*;
#(
  parameter int dataW = 32
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       divCode,
  input  logic [dataW-1:0] dividend,
  input  logic [dataW-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [dataW-1:0] out
);

  localparam logic [dataW-1:0] MINNEG = {1'b1, {(dataW-1){1'b0}}};

  state_t state_q, state_d;

  logic [1:0]       code_q;
  logic             negQ_q;
  logic             negR_q;
  logic [dataW-1:0] out_q;

  logic             load;
  logic             step;
  logic             last;
  logic [dataW-1:0] quo;
  logic [dataW-1:0] rem;

  // Special-case detection and magnitudes, evaluated on the live inputs
  logic             sgn;
  logic             divZero;
  logic             ovf;
  logic             special;
  logic [dataW-1:0] specialRes;
  logic             aNeg;
  logic             bNeg;
  logic [dataW-1:0] aMag;
  logic [dataW-1:0] bMag;
  logic             accept;

  assign sgn        = isSignedDiv(divCode);
  assign divZero    = (divisor == '0);
  assign ovf        = sgn && (dividend == MINNEG) && (divisor == '1);
  assign special    = divZero || ovf;
  assign specialRes = divZero ? (divCode[1] ? dividend : '1)
                              : (divCode[1] ? '0 : dividend);
  assign aNeg       = sgn && dividend[dataW-1];
  assign bNeg       = sgn && divisor[dataW-1];
  assign aMag       = aNeg ? (~dividend + 1'b1) : dividend;
  assign bMag       = bNeg ? (~divisor + 1'b1) : divisor;
  assign accept     = (state_q == IDLE) && start && !flush;

  div_core_r32m #(.dataW(dataW)) u_core (
    .clk         (clk),
    .nReset      (nReset),
    .load        (load),
    .step        (step),
    .dividendMag (aMag),
    .divisorMag  (bMag),
    .quo         (quo),
    .rem         (rem),
    .last        (last)
  );

  // State register
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and handshake outputs; flush overrides every transition
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start && !flush) begin
          if (special) begin
            state_d = DONE;
          end else begin
            load    = 1'b1;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) state_d = ADJUST;
      end
      ADJUST: state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Latch op and sign fix-up flags at accept; result lands in out_q either
  // at accept (special cases) or in ADJUST, and is untouched on flush
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      code_q <= '0;
      negQ_q <= 1'b0;
      negR_q <= 1'b0;
      out_q  <= '0;
    end else if (accept) begin
      code_q <= divCode;
      negQ_q <= aNeg ^ bNeg;
      negR_q <= aNeg;
      if (special) out_q <= specialRes;
    end else if ((state_q == ADJUST) && !flush) begin
      if (code_q[1]) out_q <= negR_q ? (~rem + 1'b1) : rem;
      else           out_q <= negQ_q ? (~quo + 1'b1) : quo;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_sdiv_r32m.sv
// tb/tb_sdiv_r32m.sv - self-checking bench for sdiv_r32m
module tb_sdiv_r32m;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  divCode = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        ready;
  logic        done;
  logic [31:0] out;

  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] sb[$];
  logic [31:0] last_out = '0;

  sdiv_r32m #(.dataW(32)) dut (
    .clk      (clk),
    .nReset   (nReset),
    .start    (start),
    .flush    (flush),
    .divCode  (divCode),
    .dividend (dividend),
    .divisor  (divisor),
    .ready    (ready),
    .done     (done),
    .out      (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sbv;
    sa  = a;
    sbv = b;
    if (b == 32'd0) return c[1] ? a : 32'hFFFF_FFFF;
    if (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return c[1] ? 32'd0 : 32'h8000_0000;
    case (c)
      2'b00:   return 32'(sa / sbv);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sbv);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    start = 1'b0;
    flush = 1'b0;
  endtask

  task automatic issue(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    divCode  = c;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    cyc      = 0;
    sb.push_back(exp);
  endtask

  task automatic wait_done(input string tag, input int lat);
    int got;
    logic [31:0] exp;
    got = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done === 1'b1) begin
        got = cyc;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(got), 32'(lat));
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      if (got >= 0) chk({tag, "_out"}, out, exp);
      last_out = exp;
    end
  endtask

  task automatic after_done(input string tag);
    tick();
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, ready}, 32'd1);
  endtask

  task automatic no_done(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [1:0]  rc;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_out", out, 32'd0);
    nReset = 1'b1;
    tick();

    // Directed arithmetic and special cases
    issue(2'b00, 32'd20, 32'd3, 32'd6);                     wait_done("div_20_3", 34);      after_done("div_20_3");
    issue(2'b10, 32'd20, 32'd3, 32'd2);                     wait_done("rem_20_3", 34);      after_done("rem_20_3");
    issue(2'b10, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE);      wait_done("rem_m20_3", 34);     after_done("rem_m20_3");
    issue(2'b00, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA);      wait_done("div_m20_3", 34);     after_done("div_m20_3");
    issue(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF);      wait_done("divu_max_2", 34);    after_done("divu_max_2");
    issue(2'b11, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F);     wait_done("remu_max_16", 34);   after_done("remu_max_16");
    issue(2'b00, 32'hFFFF_FFFF, 32'd2, 32'd0);              wait_done("div_m1_2", 34);      after_done("div_m1_2");
    issue(2'b00, 32'h8000_0000, 32'd1, 32'h8000_0000);      wait_done("div_min_1", 34);     after_done("div_min_1");
    issue(2'b01, 32'd7, 32'd0, 32'hFFFF_FFFF);              wait_done("divu_by0", 1);       after_done("divu_by0");
    issue(2'b00, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);      wait_done("div_by0", 1);        after_done("div_by0");
    issue(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);      wait_done("rem_by0", 1);        after_done("rem_by0");
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); wait_done("div_ovf", 1);     after_done("div_ovf");
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);      wait_done("rem_ovf", 1);        after_done("rem_ovf");

    // Start while busy is ignored; back-to-back start right after done
    issue(2'b01, 32'd100, 32'd7, 32'd14);
    while (cyc < 10) tick();
    chk("busy_ready", {31'd0, ready}, 32'd0);
    divCode  = 2'b01;
    dividend = 32'd1000;
    divisor  = 32'd1;
    start    = 1'b1;
    wait_done("ignored_start", 34);
    tick();
    chk("b2b_ready", {31'd0, ready}, 32'd1);
    issue(2'b11, 32'd100, 32'd7, 32'd2);
    wait_done("b2b", 34);
    after_done("b2b");

    // Flush mid-operation
    issue(2'b00, 32'd50, 32'd5, 32'd10);
    void'(sb.pop_back());
    while (cyc < 15) tick();
    flush = 1'b1;
    tick();
    chk("flush_ready", {31'd0, ready}, 32'd1);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_out", out, last_out);
    no_done("flush_nodone", 40);

    // Flush and start together in IDLE: start dropped
    issue(2'b01, 32'd9, 32'd0, 32'hFFFF_FFFF);
    void'(sb.pop_back());
    flush = 1'b1;
    tick();
    chk("fs_ready", {31'd0, ready}, 32'd1);
    no_done("fs_nodone", 40);
    chk("fs_out", out, last_out);

    // Flush during DONE: pulse still delivered
    issue(2'b01, 32'd9, 32'd0, 32'hFFFF_FFFF);
    wait_done("flush_in_done", 1);
    flush = 1'b1;
    #1;
    chk("fd_done", {31'd0, done}, 32'd1);
    after_done("fd");

    // Asynchronous reset mid-operation
    issue(2'b01, 32'd1000, 32'd3, 32'd333);
    void'(sb.pop_back());
    while (cyc < 20) tick();
    nReset = 1'b0;
    #1;
    chk("arst_ready", {31'd0, ready}, 32'd1);
    chk("arst_out", out, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    tick();
    nReset = 1'b1;
    last_out = '0;
    no_done("arst_nodone", 40);

    // Random vectors against the reference model
    for (int k = 0; k < 300; k++) begin
      rc  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = '0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 20));
      else if (sel == 3) rb = -32'($urandom_range(1, 20));
      issue(rc, ra, rb, ref_model(rc, ra, rb));
      wait_done("rand", ref_lat(rc, ra, rb));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
